// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake and an optional 2-entry skid buffer.
// The control field is squashed on bubble or flush. Also reports occupancy and a saturating stall counter.
module pipe_stage_reg #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 106,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_valid, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl,  main_ctrl_d;
  logic [DATA_W-1:0] main_data,  main_data_d;
  logic              skid_valid, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data,  skid_data_d;
  logic              in_xfer;

  // With the skid buffer, in_ready comes straight from a flop, so it has no path from out_ready.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = ~skid_valid;
    end else begin : g_comb_ready
      assign in_ready = ~main_valid | out_ready;
    end
  endgenerate

  assign in_xfer = in_valid & in_ready;

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path through this block can infer a latch.
    main_valid_d = main_valid;
    main_ctrl_d  = main_ctrl;
    main_data_d  = main_data;
    skid_valid_d = skid_valid;
    skid_ctrl_d  = skid_ctrl;
    skid_data_d  = skid_data;
    if (flush) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (!main_valid || out_ready) begin
      // Main is empty or draining. The skid entry is older than any new input, so it goes first.
      if (skid_valid) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl;
        main_data_d  = skid_data;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
      end else if (in_xfer) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
      end
    end else if (in_xfer && SKID != 0) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the edge.
    if (reset) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      occupancy  <= 2'd0;
    end else begin
      main_valid <= main_valid_d;
      main_ctrl  <= main_ctrl_d;
      main_data  <= main_data_d;
      skid_valid <= skid_valid_d;
      skid_ctrl  <= skid_ctrl_d;
      skid_data  <= skid_data_d;
      occupancy  <= {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end
  end

  // The stall counter survives flush and is cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

endmodule
